// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing defaults, coordinate width and the RGB332 expander
// used by the display output stage.
package vga_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int H_FP       = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BP       = 48;
    localparam int V_ACTIVE   = 480;
    localparam int V_FP       = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 33;
    localparam int PIPE_DELAY = 2;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int COORD_W = 11;

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } sync_t;

    // Bit replication keeps 0x00 -> 0x00 and full scale -> 0xFF on every channel.
    function automatic logic [23:0] rgb332_expand(input logic [7:0] rgb);
        return {rgb[7:5], rgb[7:5], rgb[7:6],
                rgb[4:2], rgb[4:2], rgb[4:3],
                {4{rgb[1:0]}}};
    endfunction

endpackage

// File: rtl/vga_timing_out_sync_delay.sv
// Clearable shift register that delays the raw sync/active bundle so it lines up
// with the pixel returning from the drawing pipeline. DEPTH=0 is a plain wire.
module sync_delay #(
    parameter int                DEPTH       = 2,
    parameter int                WIDTH       = 3,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q_o = d_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VALUE;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_out.sv
// Final display stage: raster counters for the drawing objects, plus sync/blank
// re-aligned to the returning RGB332 pixel and expanded to 8-bit DAC channels.
module vga_timing_out #(
    parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int H_FP       = vga_pkg::H_FP,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BP       = vga_pkg::H_BP,
    parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int V_FP       = vga_pkg::V_FP,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BP       = vga_pkg::V_BP,
    parameter int PIPE_DELAY = vga_pkg::PIPE_DELAY
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic [7:0]                  RGBIn,
    output logic [vga_pkg::COORD_W-1:0] pixelX,
    output logic [vga_pkg::COORD_W-1:0] pixelY,
    output logic                        startOfFrame,
    output logic                        vgaHS,
    output logic                        vgaVS,
    output logic                        vgaBlankN,
    output logic [7:0]                  vgaR,
    output logic [7:0]                  vgaG,
    output logic [7:0]                  vgaB
);

    import vga_pkg::*;

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(HT - 1);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(VT - 1);
    localparam logic [COORD_W-1:0] H_VIS      = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS      = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END     = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END     = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

    logic [COORD_W-1:0] hCnt_q, hCnt_d;
    logic [COORD_W-1:0] vCnt_q, vCnt_d;

    sync_t rawSync;
    sync_t dlySync;

    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blankN_q, blankN_d;
    logic [23:0] rgb_q, rgb_d;

    // Line counter wraps every clock period of a line; the frame counter only
    // advances (and wraps) on that same line-wrap clock.
    always_comb begin
        hCnt_d = hCnt_q + 1'b1;
        vCnt_d = vCnt_q;
        if (hCnt_q == H_LAST) begin
            hCnt_d = '0;
            vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hCnt_q <= '0;
            vCnt_q <= '0;
        end else begin
            hCnt_q <= hCnt_d;
            vCnt_q <= vCnt_d;
        end
    end

    always_comb begin
        rawSync.hs     = !((hCnt_q >= HS_START) && (hCnt_q < HS_END));
        rawSync.vs     = !((vCnt_q >= VS_START) && (vCnt_q < VS_END));
        rawSync.active = (hCnt_q < H_VIS) && (vCnt_q < V_VIS);
    end

    sync_delay #(
        .DEPTH       (PIPE_DELAY),
        .WIDTH       ($bits(sync_t)),
        .RESET_VALUE (SYNC_IDLE)
    ) u_sync_delay (
        .clk    (clk),
        .resetN (resetN),
        .d_i    (rawSync),
        .q_o    (dlySync)
    );

    // Blanked pixels are forced black whatever the mux is still presenting.
    always_comb begin
        hs_d     = dlySync.hs;
        vs_d     = dlySync.vs;
        blankN_d = dlySync.active;
        rgb_d    = dlySync.active ? rgb332_expand(RGBIn) : 24'h000000;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            blankN_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            blankN_q <= blankN_d;
            rgb_q    <= rgb_d;
        end
    end

    // Gated by reset so the pulse is low while held and lands on the first clock after release.
    assign startOfFrame = resetN && (hCnt_q == '0) && (vCnt_q == '0);

    assign pixelX    = hCnt_q;
    assign pixelY    = vCnt_q;
    assign vgaHS     = hs_q;
    assign vgaVS     = vs_q;
    assign vgaBlankN = blankN_q;
    assign vgaR      = rgb_q[23:16];
    assign vgaG      = rgb_q[15:8];
    assign vgaB      = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_out.sv
// Scoreboard bench for vga_timing_out: full-width lines with a shortened frame height,
// reference model derived from cycle count since reset release.
module tb_vga_timing_out;

    localparam int HA = 640;
    localparam int HF = 16;
    localparam int HS = 96;
    localparam int HB = 48;
    localparam int HT = HA + HF + HS + HB;
    localparam int VA = 24;
    localparam int VF = 4;
    localparam int VS = 2;
    localparam int VB = 5;
    localparam int VT = VA + VF + VS + VB;
    localparam int PD = 2;
    localparam int FRAME = HT * VT;
    localparam int MID_RESET = FRAME + 12 * HT + 700;

    logic        clk = 1'b0;
    logic        resetN;
    logic [7:0]  RGBIn;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic        vgaHS;
    logic        vgaVS;
    logic        vgaBlankN;
    logic [7:0]  vgaR;
    logic [7:0]  vgaG;
    logic [7:0]  vgaB;

    typedef struct packed {
        logic [10:0] px;
        logic [10:0] py;
        logic        sof;
        logic        hs;
        logic        vs;
        logic        blank;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   failures = 0;
    bit   monOn = 1'b0;
    int   hsRun = 0;
    int   vsRun = 0;
    int   bnRun = 0;
    int   monCycle = 0;
    int   lastSof = -1;

    vga_timing_out #(
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VS),
        .V_BP     (VB)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .RGBIn        (RGBIn),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .startOfFrame (startOfFrame),
        .vgaHS        (vgaHS),
        .vgaVS        (vgaVS),
        .vgaBlankN    (vgaBlankN),
        .vgaR         (vgaR),
        .vgaG         (vgaG),
        .vgaB         (vgaB)
    );

    always #20 clk = ~clk;

    function automatic logic [7:0] scale3(input int v);
        return 8'((v * 255 + 3) / 7);
    endfunction

    // Expected outputs for cycle m after release; controls and colour follow the
    // coordinate issued PD+1 cycles earlier, colour from RGBIn of cycle m-1.
    function automatic exp_t model(input int m, input logic [7:0] rgbPrev);
        exp_t e;
        int   k, h, v;
        bit   act;
        e.px  = 11'(m % HT);
        e.py  = 11'((m / HT) % VT);
        e.sof = ((m % FRAME) == 0);
        k = m - (PD + 1);
        if (k < 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0;
            e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
        end else begin
            h = k % HT;
            v = (k / HT) % VT;
            act = (h < HA) && (v < VA);
            e.hs    = !((h >= HA + HF) && (h < HA + HF + HS));
            e.vs    = !((v >= VA + VF) && (v < VA + VF + VS));
            e.blank = act;
            if (act) begin
                e.r = scale3(int'(rgbPrev[7:5]));
                e.g = scale3(int'(rgbPrev[4:2]));
                e.b = 8'(int'(rgbPrev[1:0]) * 85);
            end else begin
                e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input exp_t e, input string name);
        exp_t a;
        a = '{pixelX, pixelY, startOfFrame, vgaHS, vgaVS, vgaBlankN, vgaR, vgaG, vgaB};
        checks++;
        if (a !== e) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d got px=%0d py=%0d sof=%b hs=%b vs=%b bn=%b rgb=%h_%h_%h need px=%0d py=%0d sof=%b hs=%b vs=%b bn=%b rgb=%h_%h_%h",
                     name, monCycle, a.px, a.py, a.sof, a.hs, a.vs, a.blank, a.r, a.g, a.b,
                     e.px, e.py, e.sof, e.hs, e.vs, e.blank, e.r, e.g, e.b);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d got=%0d need=%0d", name, monCycle, act, req);
        end
    endtask

    // Drives the pixel the mux would return for the coordinate issued PD cycles ago.
    task automatic applyStimulus(input int n);
        int         c, h2, v2;
        logic [7:0] rgb;
        rgb = 8'($urandom_range(0, 255));
        c = n - PD;
        if (c >= 0) begin
            h2 = c % HT;
            v2 = (c / HT) % VT;
            if (v2 == 5)                 rgb = (h2 == 10) ? 8'hE0 : 8'h00;
            else if (v2 == 6 || v2 == 7) rgb = 8'hFF;
            else if (v2 == 8)            rgb = 8'h49;
        end
        RGBIn = rgb;
        expQ.push_back(model(n + 1, rgb));
    endtask

    always @(negedge clk) begin
        if (!monOn) begin
            hsRun = 0;
            vsRun = 0;
            bnRun = 0;
            monCycle = 0;
            lastSof = -1;
        end else begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL scoreboard_empty cyc=%0d got=0 entries need>=1", monCycle);
            end else begin
                checkOutput(expQ.pop_front(), "pixel_out");
            end
            if (!vgaHS) hsRun++;
            else begin
                if (hsRun > 0) checkValue("hs_low_len", hsRun, HS);
                hsRun = 0;
            end
            if (!vgaVS) vsRun++;
            else begin
                if (vsRun > 0) checkValue("vs_low_len", vsRun, VS * HT);
                vsRun = 0;
            end
            if (vgaBlankN) bnRun++;
            else begin
                if (bnRun > 0) checkValue("blank_high_len", bnRun, HA);
                bnRun = 0;
            end
            if (startOfFrame) begin
                if (lastSof >= 0) checkValue("sof_period", monCycle - lastSof, FRAME);
                lastSof = monCycle;
            end
            monCycle++;
        end
    end

    localparam exp_t RESET_EXP = '{11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};

    initial begin
        resetN = 1'b0;
        RGBIn  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput(RESET_EXP, "reset_state");

        @(posedge clk); #1;
        $display("[TB] releasing reset, running to mid-frame reset point");
        resetN = 1'b1;
        expQ.delete();
        expQ.push_back(model(0, 8'h00));
        monOn = 1'b1;
        for (int n = 0; n < MID_RESET; n++) begin
            applyStimulus(n);
            @(posedge clk); #1;
        end

        monOn = 1'b0;
        expQ.delete();
        resetN = 1'b0;
        RGBIn = 8'hFF;
        #1;
        checkOutput(RESET_EXP, "reset_immediate");
        repeat (3) begin
            @(negedge clk);
            checkOutput(RESET_EXP, "reset_hold");
            @(posedge clk);
        end
        #1;

        $display("[TB] releasing mid-frame reset");
        resetN = 1'b1;
        expQ.push_back(model(0, 8'h00));
        monOn = 1'b1;
        for (int n = 0; n < FRAME + 2000; n++) begin
            applyStimulus(n);
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        monOn = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
